// File: rtl/key_conditioner.sv
// Debounce, edge-pulse and auto-repeat for a bank of active-low push buttons.
// The release/repeat outputs carry an _o suffix because both words are reserved in SystemVerilog.
module key_conditioner #(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             CLK_50A,
  input  logic             reset_n,
  input  logic [NKEYS-1:0] KEY,
  output logic [NKEYS-1:0] pressed,
  output logic [NKEYS-1:0] press,
  output logic [NKEYS-1:0] release_o,
  output logic [NKEYS-1:0] repeat_o,
  output logic             any_pressed
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX + 1);
  localparam bit REPEAT_EN = (REPEAT_DELAY > 0);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] DLY_LAST = HW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);

  logic [NKEYS-1:0] sync1_q, sync2_q;
  logic [NKEYS-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [NKEYS];
  logic [CW-1:0]    cnt_d [NKEYS];
  logic [HW-1:0]    hold_q [NKEYS];
  logic [HW-1:0]    hold_d [NKEYS];
  logic [NKEYS-1:0] phase_q, phase_d;
  logic [NKEYS-1:0] press_q, press_d;
  logic [NKEYS-1:0] release_q, release_d;
  logic [NKEYS-1:0] repeat_q, repeat_d;
  logic             any_q, any_d;

  always_comb begin
    stable_d  = stable_q;
    phase_d   = phase_q;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    for (int i = 0; i < NKEYS; i++) begin
      cnt_d[i]  = cnt_q[i];
      hold_d[i] = hold_q[i];
      // Debounce: any agreement with the stable level restarts the count.
      if (~sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        stable_d[i]  = ~sync2_q[i];
        cnt_d[i]     = '0;
        press_d[i]   = ~sync2_q[i];
        release_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
      // Hold counter reloads at each repeat, so it never wraps; phase selects delay vs period.
      if (!REPEAT_EN || press_d[i] || release_d[i] || !stable_q[i]) begin
        hold_d[i]  = '0;
        phase_d[i] = 1'b0;
      end else if (hold_q[i] == (phase_q[i] ? PER_LAST : DLY_LAST)) begin
        repeat_d[i] = 1'b1;
        hold_d[i]   = '0;
        phase_d[i]  = 1'b1;
      end else begin
        hold_d[i] = hold_q[i] + HW'(1);
      end
    end
    any_d = |stable_d;
  end

  always_ff @(posedge CLK_50A or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      stable_q  <= '0;
      cnt_q     <= '{default: '0};
      hold_q    <= '{default: '0};
      phase_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      any_q     <= 1'b0;
    end else begin
      sync1_q   <= KEY;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      phase_q   <= phase_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      any_q     <= any_d;
    end
  end

  assign pressed     = stable_q;
  assign press       = press_q;
  assign release_o   = release_q;
  assign repeat_o    = repeat_q;
  assign any_pressed = any_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: expected pulses are queued with their cycle stamps
// and a negedge monitor matches every press/release/repeat pulse against the queue.
module tb_key_conditioner;

  localparam int W = 24; // {cycle[15:0], kind[3:0], mask[3:0]}, kind 0=press 1=release 2=repeat

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] KEY;
  logic [3:0] pressed, press, release_o, repeat_o;
  logic       any_pressed;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  key_conditioner #(
    .NKEYS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .CLK_50A(clk), .reset_n(reset_n), .KEY(KEY), .pressed(pressed), .press(press),
    .release_o(release_o), .repeat_o(repeat_o), .any_pressed(any_pressed)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int kind, input logic [3:0] mask);
    exp_q.push_back({16'(c), 4'(kind), mask});
  endtask

  // Press at p, repeats every 3 cycles starting 10 after p while still held, release at r.
  task automatic expect_hold(input logic [3:0] mask, input int p, input int r);
    push(p, 0, mask);
    for (int t = p + 10; t < r; t += 3) push(t, 2, mask);
    push(r, 1, mask);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver tasks
  task automatic hold_key(input int k, input int hold);
    int c;
    c = cyc;
    expect_hold(4'(1 << k), c + 6, c + hold + 6);
    KEY[k] = 1'b0;
    tick(5);
    chk("pressed_before_edge6", 32'(pressed[k]), 0);
    tick(1);
    chk("pressed_after_edge6", 32'(pressed[k]), 1);
    chk("any_pressed_single", 32'(any_pressed), 1);
    tick(hold - 6);
    KEY[k] = 1'b1;
    tick(5);
    chk("pressed_before_release", 32'(pressed[k]), 1);
    tick(1);
    chk("pressed_after_release", 32'(pressed[k]), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [15:0] now;
    logic [3:0]  m;
    logic [W-1:0] e;
    now = cyc[15:0];
    while (exp_q.size() > 0 && exp_q[0][23:8] < now) begin
      checks++;
      failures++;
      $display("FAIL missed_event actual=none expected=%h cycle=%0d", exp_q[0], now);
      void'(exp_q.pop_front());
    end
    for (int k = 0; k < 3; k++) begin
      m = (k == 0) ? press : (k == 1) ? release_o : repeat_o;
      if (m != 4'd0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event actual=%h expected=none", {now, 4'(k), m});
        end else begin
          e = exp_q.pop_front();
          chk("event", 32'({now, 4'(k), m}), 32'(e));
        end
      end
    end
  end

  initial begin
    int c, r;
    logic [3:0] bounce [8];
    bounce = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    reset_n = 1'b0;
    KEY = 4'hF;
    tick(3);
    chk("reset_outputs", 32'({pressed, press, release_o, repeat_o, any_pressed}), 0);
    reset_n = 1'b1;
    tick(10);
    chk("idle_pressed", 32'(pressed), 0);

    // long hold on key 0, then key 2 with its repeat train and silence after release
    hold_key(0, 20);
    tick(5);
    hold_key(2, 20);
    tick(12);
    chk("no_repeat_after_release", 32'(pressed), 0);

    // key 1 bounce: every excursion is shorter than the debounce window
    for (int i = 0; i < 8; i++) begin
      KEY[1] = bounce[i][0];
      tick(1);
      chk("bounce_pressed", 32'(pressed[1]), 0);
    end
    tick(8);
    chk("bounce_settled", 32'(pressed), 0);

    // simultaneous press on keys 0 and 3
    c = cyc;
    push(c + 6, 0, 4'b1001);
    push(c + 14, 1, 4'b1001);
    KEY[0] = 1'b0;
    KEY[3] = 1'b0;
    tick(6);
    chk("dual_pressed", 32'(pressed), 32'h9);
    chk("dual_any", 32'(any_pressed), 1);
    tick(2);
    KEY[0] = 1'b1;
    KEY[3] = 1'b1;
    tick(6);
    chk("dual_released", 32'(pressed), 0);
    chk("dual_any_clear", 32'(any_pressed), 0);
    tick(4);

    // reset mid-debounce on key 1 while key 3 is held
    c = cyc;
    push(c + 6, 0, 4'b1000);
    KEY[3] = 1'b0;
    tick(7);
    KEY[1] = 1'b0;
    tick(2);
    chk("pre_reset_pressed", 32'(pressed), 32'h8);
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({pressed, press, release_o, repeat_o, any_pressed}), 0);
    tick(2);
    r = cyc;
    push(r + 6, 0, 4'b1010);
    push(r + 14, 1, 4'b1010);
    reset_n = 1'b1;
    tick(5);
    chk("post_reset_before_edge6", 32'(pressed), 0);
    tick(1);
    chk("post_reset_pressed", 32'(pressed), 32'hA);
    tick(2);
    KEY = 4'hF;
    tick(8);
    chk("final_released", 32'(pressed), 0);
    tick(20);
    chk("queue_empty", 32'(exp_q.size()), 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter NKEYS, default 4: number of push-button inputs.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: stable cycles required to accept a level change (20 ms at 50 MHz); legal range >= 1.
REQ-003 SHALL have parameter REPEAT_DELAY, default 25000000: cycles from accepted press to first auto-repeat pulse; 0 disables auto-repeat.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 5000000: cycles between subsequent repeat pulses; legal range >= 1.
REQ-005 SHALL have port CLK_50A, input, 1 bit: the only clock; all state on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port KEY, input, NKEYS bits: raw asynchronous buttons, active-low (0 = pressed).
REQ-008 SHALL have port pressed, output, NKEYS bits: debounced level, active-high.
REQ-009 SHALL have port press, output, NKEYS bits: one-cycle pulse on accepted press.
REQ-010 SHALL have port release, output, NKEYS bits: one-cycle pulse on accepted release.
REQ-011 SHALL have port repeat, output, NKEYS bits: one-cycle auto-repeat pulse while held.
REQ-012 SHALL have port any_pressed, output, 1 bit: OR of pressed.

Function
REQ-013 SHALL pass each KEY bit through a two-flop synchronizer; the second-stage value (sync) is the only use of KEY.
REQ-014 SHALL invert sync so that 1 = pressed before comparison with the stable state.
REQ-015 SHALL keep per key a stable bit and a debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-016 SHALL clear the debounce counter on any cycle where the inverted sync equals stable.
REQ-017 SHALL, while they differ, increment the counter; when it equals DEBOUNCE_CYCLES-1 and they still differ, toggle stable and clear the counter instead.
REQ-018 SHALL make stable change at the (DEBOUNCE_CYCLES+2)th rising edge after the first edge that samples a new, thereafter constant, KEY level.
REQ-019 SHALL assert press[i] (release[i]) for exactly the one cycle following the edge where stable[i] goes 0->1 (1->0); pressed[i] updates on that same edge.
REQ-020 SHALL discard any KEY excursion shorter than DEBOUNCE_CYCLES synchronized cycles without output activity, restarting the count on each bounce.
REQ-021 SHALL, with REPEAT_DELAY>0, keep per key a hold counter cleared on press and on release and counting while stable=1.
REQ-022 SHALL pulse repeat[i] when the hold counter reaches REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles while held; the counter saturates/reloads so no wrap-around produces stray pulses.
REQ-023 SHALL never assert repeat[i] in the same cycle as press[i] or release[i], and SHALL emit no repeat after release.
REQ-024 SHALL process all keys independently; simultaneous events on several keys produce simultaneous pulses.
REQ-025 SHALL register all outputs (no combinational path from KEY).

Reset
REQ-026 SHALL, on reset_n=0, immediately force synchronizer flops to released, stable, counters, pressed, press, release, repeat and any_pressed to 0.
REQ-027 SHALL treat a key held across reset deassertion as a new press, giving a press pulse DEBOUNCE_CYCLES+2 edges after reset release.
REQ-028 SHALL abandon an in-progress debounce or repeat sequence on reset with no pulse emitted.

Verification (bench: NKEYS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 SHALL cover: KEY[0] 1->0 held -> pressed[0]=1 and press[0] one cycle after edge 6; release after long hold -> release[0] one cycle, pressed[0]=0 after edge 6.
REQ-030 SHALL cover: KEY[1] bounces low 3 cycles, high 1, low 3, high -> no press/pressed activity.
REQ-031 SHALL cover: KEY[2] held 20 cycles past press -> repeat[2] pulses 10, 13, 16, 19 cycles after press pulse; none after release.
REQ-032 SHALL cover: KEY[0] and KEY[3] fall on same edge -> press[0] and press[3] same cycle; any_pressed=1.
REQ-033 SHALL cover: reset_n pulsed low mid-debounce with KEY[1]=0 -> all outputs 0 at once; press[1] 6 edges after reset_n rises.
